// File: rtl/div_count_n_if.sv
// Handshake bundle for div_count_n: control inputs and the divided/tick outputs.
// The master side drives en/clr/div_val; the slave side is the divider.
interface div_count_n_if #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 4
);
    logic             en;
    logic             clr;
    logic [DIV_W-1:0] div_val;
    logic             div_pulse;
    logic             div_clk;
    logic [CNT_W-1:0] po_cnt;
    logic             cnt_wrap;

    modport master (
        output en, clr, div_val,
        input  div_pulse, div_clk, po_cnt, cnt_wrap
    );

    modport slave (
        input  en, clr, div_val,
        output div_pulse, div_clk, po_cnt, cnt_wrap
    );
endinterface

// File: rtl/div_count_n.sv
// Programmable divide-by-N tick generator with tick counter and optional divided clock.
// Define DIV_COUNT_N_DIVCLK_EN to build the registered div_clk output; otherwise it is tied to 0.
module div_count_n #(
    parameter int DIV_W   = 8,
    parameter int CNT_W   = 4,
    parameter int DIV_DEF = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    div_count_n_if.slave bus
);

    logic [DIV_W-1:0] div_n;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] n_eff;
    logic             period_end;
    logic             div_pulse_q;
    logic [CNT_W-1:0] po_cnt_q;
    logic             cnt_wrap_q;

    // Ratios below 2 cannot produce a distinct tick, so they saturate up to 2.
    function automatic logic [DIV_W-1:0] sat_ratio(input logic [DIV_W-1:0] n);
        return (n < DIV_W'(2)) ? DIV_W'(2) : n;
    endfunction

    assign n_eff      = sat_ratio(div_n);
    assign period_end = (div_cnt == n_eff - DIV_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            div_n       <= DIV_W'(DIV_DEF);
            div_pulse_q <= 1'b0;
        end else if (bus.clr) begin
            div_cnt     <= '0;
            div_n       <= bus.div_val;
            div_pulse_q <= 1'b0;
        end else if (bus.en) begin
            if (period_end) begin
                div_cnt     <= '0;
                div_n       <= bus.div_val;
                div_pulse_q <= 1'b1;
            end else begin
                div_cnt     <= div_cnt + DIV_W'(1);
                div_pulse_q <= 1'b0;
            end
        end else begin
            div_pulse_q <= 1'b0;
        end
    end

    // Tick counter trails div_pulse by one edge and ignores en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            po_cnt_q   <= '0;
            cnt_wrap_q <= 1'b0;
        end else if (bus.clr) begin
            po_cnt_q   <= '0;
            cnt_wrap_q <= 1'b0;
        end else begin
            cnt_wrap_q <= div_pulse_q && (po_cnt_q == '1);
            if (div_pulse_q) begin
                po_cnt_q <= po_cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef DIV_COUNT_N_DIVCLK_EN
    logic             div_clk_q;
    logic [DIV_W-1:0] half_m1;

    // High for floor(N/2) cycles starting at the tick, low for the remainder.
    assign half_m1 = (n_eff >> 1) - DIV_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_clk_q <= 1'b0;
        end else if (bus.clr) begin
            div_clk_q <= 1'b0;
        end else if (bus.en) begin
            if (period_end) begin
                div_clk_q <= 1'b1;
            end else if (div_cnt == half_m1) begin
                div_clk_q <= 1'b0;
            end
        end
    end

    assign bus.div_clk = div_clk_q;
`else
    assign bus.div_clk = 1'b0;
`endif

    assign bus.div_pulse = div_pulse_q;
    assign bus.po_cnt    = po_cnt_q;
    assign bus.cnt_wrap  = cnt_wrap_q;

endmodule

// File: tb/tb_div_count_n.sv
// Directed bench for div_count_n: reset, ratio changes, clamping, wrap, enable stall, async reset and clr.
// div_clk expectations follow DIV_COUNT_N_DIVCLK_EN (constant 0 when undefined).
module tb_div_count_n;

    localparam int DIV_W = 8;
    localparam int CNT_W = 4;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    div_count_n_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

    div_count_n #(.DIV_W(DIV_W), .CNT_W(CNT_W), .DIV_DEF(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic clk_exp(input logic v);
`ifdef DIV_COUNT_N_DIVCLK_EN
        return v;
`else
        return 1'b0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_pulse"}, 32'(bus.div_pulse), 32'd0);
        check({tag, "_clk"},   32'(bus.div_clk),   32'd0);
        check({tag, "_pocnt"}, 32'(bus.po_cnt),    32'd0);
        check({tag, "_wrap"},  32'(bus.cnt_wrap),  32'd0);
    endtask

    task automatic do_clr(input logic [DIV_W-1:0] v);
        bus.clr     = 1'b1;
        bus.div_val = v;
        step();
        bus.clr = 1'b0;
        check_idle("clr");
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        bus.en      = 1'b0;
        bus.clr     = 1'b0;
        bus.div_val = 8'd4;
        step();
        step();
        check_idle("rst");

        // Default ratio 4 from reset: ticks on edges 4,8,12; po_cnt follows one edge later.
        rst_n  = 1'b1;
        bus.en = 1'b1;
        for (int e = 1; e <= 13; e++) begin
            step();
            check("t1_pulse", 32'(bus.div_pulse), 32'((e % 4) == 0));
            check("t1_pocnt", 32'(bus.po_cnt), 32'((e - 1) / 4));
            check("t1_clk", 32'(bus.div_clk), 32'(clk_exp((e >= 4) && (((e - 4) % 4) < 2))));
        end

        // Mid-period change to 5: first period keeps 4, then 5-cycle periods (high 2, low 3).
        do_clr(8'd4);
        for (int e = 1; e <= 14; e++) begin
            step();
            if (e == 1) bus.div_val = 8'd5;
            check("t2_pulse", 32'(bus.div_pulse), 32'((e == 4) || (e == 9) || (e == 14)));
            check("t2_clk", 32'(bus.div_clk), 32'(clk_exp((e >= 4) && (((e - 4) % 5) < 2))));
        end

        // Ratios 0 and 1 clamp to 2.
        for (int v = 0; v <= 1; v++) begin
            do_clr(DIV_W'(v));
            for (int e = 1; e <= 8; e++) begin
                step();
                check("t3_pulse", 32'(bus.div_pulse), 32'((e % 2) == 0));
                check("t3_clk", 32'(bus.div_clk), 32'(clk_exp((e % 2) == 0)));
            end
        end

        // N=2, 16 ticks: po_cnt wraps 15->0 on edge 33 with a single-cycle cnt_wrap.
        do_clr(8'd2);
        for (int e = 1; e <= 34; e++) begin
            step();
            check("t4_pocnt", 32'(bus.po_cnt), 32'(((e - 1) / 2) % 16));
            check("t4_wrap", 32'(bus.cnt_wrap), 32'(e == 33));
        end

        // N=4, en low for three edges while div_cnt==2: tick moves from edge 8 to edge 11.
        do_clr(8'd4);
        for (int e = 1; e <= 11; e++) begin
            bus.en = !((e >= 7) && (e <= 9));
            step();
            check("t5_pulse", 32'(bus.div_pulse), 32'((e == 4) || (e == 11)));
            check("t5_clk", 32'(bus.div_clk), 32'(clk_exp((e == 4) || (e == 5) || (e == 11))));
        end
        bus.en = 1'b1;

        // Reach po_cnt=7 at N=2, then assert rst_n between clock edges.
        do_clr(8'd2);
        for (int e = 1; e <= 15; e++) step();
        check("t6_pocnt7", 32'(bus.po_cnt), 32'd7);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle("arst");
        bus.div_val = 8'd4;
        step();
        rst_n = 1'b1;
        for (int e = 1; e <= 4; e++) step();
        check("t6_pulse", 32'(bus.div_pulse), 32'd1);
        check("t6_pocnt0", 32'(bus.po_cnt), 32'd0);
        // clr on the edge that would have bumped po_cnt.
        do_clr(8'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
